mips_mc_controller: RTL and testbench

- Multicycle control unit for the MIPS core. Sequences a single shared instruction/data memory, the register file, the ALU and the PC through a Moore FSM.
- Sits beside the datapath inside top. Consumes opcode/funct fields from the instruction register plus the ALU zero flag.
- Emits every datapath enable and mux select each cycle.

---
 rtl/mips_mc_pkg.sv | 53 +++++
 rtl/mips_mc_controller_if.sv | 44 ++++
 rtl/mips_mc_aludec.sv | 37 +++
 rtl/mips_mc_controller.sv | 160 ++++++++++++++++
 tb/tb_mips_mc_controller.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes, functs, ALU ops/codes.
// The optional ANDI/ORI/BNE extension is enabled with MIPS_MC_EXT_OPS_EN.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_LOGIEX  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUOP_NONE is used by states that do not drive the ALU, so alucontrol reads 000 there.
    typedef enum logic [2:0] {
        ALUOP_NONE  = 3'd0,
        ALUOP_ADD   = 3'd1,
        ALUOP_SUB   = 3'd2,
        ALUOP_FUNCT = 3'd3,
        ALUOP_AND   = 3'd4,
        ALUOP_OR    = 3'd5
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// With MIPS_MC_EXT_OPS_EN defined, the zero-extend select zext is added.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
`ifdef MIPS_MC_EXT_OPS_EN
    logic       zext;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, zext
    );
    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal, zext
    );
`else
    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
    );
    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
    );
`endif
endinterface

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps the FSM's aluop (and funct for R-type) to the ALU control code.
// bad_funct flags an unsupported funct, only meaningful when aluop is FUNCT.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       bad_funct
);

    always_comb begin
        alucontrol = 3'b000;
        bad_funct  = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD: alucontrol = ALU_ADD;
                    FN_SUB: alucontrol = ALU_SUB;
                    FN_AND: alucontrol = ALU_AND;
                    FN_OR:  alucontrol = ALU_OR;
                    FN_SLT: alucontrol = ALU_SLT;
                    default: begin
                        alucontrol = ALU_ADD;
                        bad_funct  = 1'b1;
                    end
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing memory, register file, ALU and PC.
// Defining MIPS_MC_EXT_OPS_EN adds ANDI/ORI (via LOGIEX, zext) and BNE (branchne).
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mips_mc_controller_if.master  bus
);

    state_t     state, state_next;
    aluop_t     aluop;
    logic [2:0] alucontrol_dec;
    logic       bad_funct;
    logic       pcwrite, branch, branchne, zext;
    logic       memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        aluop      = ALUOP_NONE;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        zext       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        illegal    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        case (state)
            S_FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                aluop      = ALUOP_ADD;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
`ifdef MIPS_MC_EXT_OPS_EN
                    OP_ANDI, OP_ORI: state_next = S_LOGIEX;
                    OP_BNE:          state_next = S_BRANCH;
`endif
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = ALUOP_ADD;
                state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                illegal    = bad_funct;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
`ifdef MIPS_MC_EXT_OPS_EN
                branchne = (bus.op == OP_BNE);
                branch   = (bus.op != OP_BNE);
`else
                branch   = 1'b1;
`endif
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = ALUOP_ADD;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MIPS_MC_EXT_OPS_EN
            S_LOGIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                zext       = 1'b1;
                aluop      = (bus.op == OP_ANDI) ? ALUOP_AND : ALUOP_OR;
                state_next = S_ADDIWB;
            end
`endif
            default: state_next = S_FETCH;
        endcase
    end

    mips_mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol_dec),
        .bad_funct  (bad_funct)
    );

    // Every output is forced low while reset is held, so an abandoned instruction writes nothing.
    assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero) | (branchne & ~bus.zero));
    assign bus.memwrite   = ~reset & memwrite;
    assign bus.irwrite    = ~reset & irwrite;
    assign bus.regwrite   = ~reset & regwrite;
    assign bus.iord       = ~reset & iord;
    assign bus.memtoreg   = ~reset & memtoreg;
    assign bus.regdst     = ~reset & regdst;
    assign bus.alusrca    = ~reset & alusrca;
    assign bus.alusrcb    = reset ? 2'b00 : alusrcb;
    assign bus.pcsrc      = reset ? 2'b00 : pcsrc;
    assign bus.alucontrol = reset ? 3'b000 : alucontrol_dec;
    assign bus.illegal    = ~reset & illegal;
`ifdef MIPS_MC_EXT_OPS_EN
    assign bus.zext       = ~reset & zext;
`else
    logic unused_zext;
    assign unused_zext = zext;
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: per-cycle expected control words are queued
// from a small instruction model and compared against the DUT on the falling edge.
module tb_mips_mc_controller;
    import mips_mc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] expq[$];

    always #5 clk = ~clk;

    mips_mc_controller_if bus ();

    mips_mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Packed control word: pcen memwrite irwrite regwrite iord memtoreg regdst alusrca
    // alusrcb[1:0] pcsrc[1:0] alucontrol[2:0] illegal
    function automatic logic [15:0] cw(logic pcen, logic mw, logic irw, logic rw, logic iord,
                                       logic m2r, logic rdst, logic asa, logic [1:0] asb,
                                       logic [1:0] psrc, logic [2:0] aluc, logic ill);
        return {pcen, mw, irw, rw, iord, m2r, rdst, asa, asb, psrc, aluc, ill};
    endfunction

    function automatic logic [15:0] observed();
        return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.memtoreg,
                bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock cycle: queue the expected word, compare mid-cycle, advance past the next edge.
    task automatic step(input string tag, input logic [15:0] exp);
        logic [15:0] e;
        expq.push_back(exp);
        @(negedge clk);
        e = expq.pop_front();
        check_eq(tag, observed(), e);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype_model(input logic [5:0] fn, output logic [2:0] aluc, output logic ill);
        ill = 1'b0;
        case (fn)
            6'b100000: aluc = 3'b010;
            6'b100010: aluc = 3'b110;
            6'b100100: aluc = 3'b000;
            6'b100101: aluc = 3'b001;
            6'b101010: aluc = 3'b111;
            default: begin aluc = 3'b010; ill = 1'b1; end
        endcase
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z);
        logic [15:0] fetch_w, dec_w, madr_w;
        logic [2:0]  aluc;
        logic        ill;
        fetch_w = cw(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
        dec_w   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
        madr_w  = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        bus.op = op; bus.funct = fn; bus.zero = z;
        step({name, "_fetch"}, fetch_w);
        case (op)
            6'b100011: begin
                step({name, "_decode"}, dec_w);
                step({name, "_memadr"}, madr_w);
                step({name, "_memrd"}, cw(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0));
                step({name, "_memwb"}, cw(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0));
            end
            6'b101011: begin
                step({name, "_decode"}, dec_w);
                step({name, "_memadr"}, madr_w);
                step({name, "_memwr"}, cw(0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0));
            end
            6'b000000: begin
                rtype_model(fn, aluc, ill);
                step({name, "_decode"}, dec_w);
                step({name, "_execute"}, cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aluc, ill));
                step({name, "_aluwb"}, cw(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0));
            end
            6'b000100: begin
                step({name, "_decode"}, dec_w);
                step({name, "_branch"}, cw(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
            end
            6'b001000: begin
                step({name, "_decode"}, dec_w);
                step({name, "_addiex"}, madr_w);
                step({name, "_addiwb"}, cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0));
            end
            6'b000010: begin
                step({name, "_decode"}, dec_w);
                step({name, "_jump"}, cw(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0));
            end
            default: step({name, "_decode_illegal"}, dec_w | 16'h0001);
        endcase
    endtask

    initial begin
        reset = 1'b1; bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;
        step("reset_c0", 16'h0000);
        step("reset_c1", 16'h0000);
        reset = 1'b0;

        run_instr("lw", 6'b100011, 6'b000000, 1'b0);
        run_instr("sw", 6'b101011, 6'b000000, 1'b1);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1);
        run_instr("beq_not", 6'b000100, 6'b000000, 1'b0);
        run_instr("slt", 6'b000000, 6'b101010, 1'b0);
        run_instr("sub", 6'b000000, 6'b100010, 1'b0);
        run_instr("or", 6'b000000, 6'b100101, 1'b0);
        run_instr("badfn", 6'b000000, 6'b111111, 1'b0);
        run_instr("addi", 6'b001000, 6'b000000, 1'b0);
        run_instr("j", 6'b000010, 6'b000000, 1'b0);
        run_instr("badop", 6'b111111, 6'b000000, 1'b0);
        run_instr("andi_base", 6'b001100, 6'b000000, 1'b0);
        run_instr("lw2", 6'b100011, 6'b100100, 1'b1);

        // Abandon a store in MEMWR: the strobe must drop in the reset cycle itself.
        bus.op = 6'b101011;
        step("rmw_fetch", cw(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
        step("rmw_decode", cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
        step("rmw_memadr", cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        reset = 1'b1;
        step("rmw_reset", 16'h0000);
        reset = 1'b0;
        step("rmw_after_fetch", cw(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
        step("rmw_after_decode", cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
